// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the music sequencer: FSM state encodings (also
// driven onto the LED port) and direction helpers.
package music_sequencer_pkg;

   typedef enum logic [1:0] {
      PAUSED   = 2'd0,
      PLAY_FWD = 2'd1,
      PLAY_REV = 2'd2
   } seq_state_e;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   function automatic seq_state_e play_state(input logic dir);
      return (dir == DIR_REV) ? PLAY_REV : PLAY_FWD;
   endfunction

endpackage

// File: rtl/tempo_timer.sv
// Note-duration timer: saturating tempo register plus note counter; pulses
// note_done on the cycle the current note reaches its length.
module tempo_timer #(
   parameter int TEMPO_DEFAULT = 25_000_000,
   parameter int TEMPO_STEP    = 2_500_000,
   parameter int TEMPO_MIN     = 2_500_000,
   parameter int TEMPO_MAX     = 125_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic tempo_up,
   input  logic tempo_down,
   output logic note_done
);

   localparam int TW = $clog2(TEMPO_MAX + 1);
   localparam logic [TW-1:0] T_DEF  = TW'(TEMPO_DEFAULT);
   localparam logic [TW-1:0] T_STEP = TW'(TEMPO_STEP);
   localparam logic [TW-1:0] T_MIN  = TW'(TEMPO_MIN);
   localparam logic [TW-1:0] T_MAX  = TW'(TEMPO_MAX);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   logic [TW-1:0] tempo_q, tempo_d;
   logic [TW-1:0] cnt_q, cnt_d;

   // The compare uses the updated tempo so a shortened note can end at once.
   always_comb begin
      tempo_d = tempo_q;
      if (tempo_up && !tempo_down)
         tempo_d = (tempo_q < T_MIN + T_STEP) ? T_MIN : tempo_q - T_STEP;
      else if (tempo_down && !tempo_up)
         tempo_d = (tempo_q > T_MAX - T_STEP) ? T_MAX : tempo_q + T_STEP;

      note_done = run && (cnt_q >= tempo_d - T_ONE);

      cnt_d = cnt_q;
      if (note_done)
         cnt_d = '0;
      else if (run)
         cnt_d = cnt_q + T_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tempo_q <= T_DEF;
         cnt_q   <= '0;
      end else begin
         tempo_q <= tempo_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/music_sequencer.sv
// Note sequencer: walks a note ROM forward or backward at a tempo set by
// button pulses and registers the looked-up tone period for the tone generator.
module music_sequencer
   import music_sequencer_pkg::*;
#(
   parameter int CLOCK_FREQ    = 125_000_000,
   parameter int ADDR_WIDTH    = 10,
   parameter int NOTE_WIDTH    = 24,
   parameter int TEMPO_DEFAULT = CLOCK_FREQ / 5,
   parameter int TEMPO_STEP    = CLOCK_FREQ / 50,
   parameter int TEMPO_MIN     = TEMPO_STEP,
   parameter int TEMPO_MAX     = CLOCK_FREQ
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  play_pause,
   input  logic                  reverse,
   input  logic                  tempo_up,
   input  logic                  tempo_down,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [NOTE_WIDTH-1:0] rom_data,
   output logic [NOTE_WIDTH-1:0] tone,
   output logic [1:0]            state
);

   // state    | meaning
   // PAUSED   | counter and address held, tone silenced
   // PLAY_FWD | counting, address steps +1 per note
   // PLAY_REV | counting, address steps -1 per note

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   seq_state_e            state_q, state_d;
   logic                  dir_q, dir_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [NOTE_WIDTH-1:0] tone_q, tone_d;
   logic                  run;
   logic                  note_done;

   assign run = (state_q != PAUSED);

   tempo_timer #(
      .TEMPO_DEFAULT (TEMPO_DEFAULT),
      .TEMPO_STEP    (TEMPO_STEP),
      .TEMPO_MIN     (TEMPO_MIN),
      .TEMPO_MAX     (TEMPO_MAX)
   ) u_tempo_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .tempo_up   (tempo_up),
      .tempo_down (tempo_down),
      .note_done  (note_done)
   );

   // Direction toggles first so a combined pulse resumes in the new direction.
   always_comb begin
      dir_d = dir_q ^ reverse;

      state_d = state_q;
      if (state_q == PAUSED)
         state_d = play_pause ? play_state(dir_d) : PAUSED;
      else
         state_d = play_pause ? PAUSED : play_state(dir_d);

      addr_d = addr_q;
      if (note_done)
         addr_d = (dir_d == DIR_REV) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;

      tone_d = (state_d != PAUSED) ? rom_data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PAUSED;
         dir_q   <= DIR_FWD;
         addr_q  <= '0;
         tone_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         addr_q  <= addr_d;
         tone_q  <= tone_d;
      end
   end

   assign rom_addr = addr_q;
   assign tone     = tone_q;
   assign state    = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a small registered ROM holding i+1.
module tb_music_sequencer;

   logic        clk;
   logic        rst_n;
   logic        play_pause;
   logic        reverse;
   logic        tempo_up;
   logic        tempo_down;
   logic [2:0]  rom_addr;
   logic [23:0] rom_data;
   logic [23:0] tone;
   logic [1:0]  state;

   int total;
   int bad;
   int since_step;

   music_sequencer #(
      .ADDR_WIDTH    (3),
      .NOTE_WIDTH    (24),
      .TEMPO_DEFAULT (10),
      .TEMPO_STEP    (2),
      .TEMPO_MIN     (2),
      .TEMPO_MAX     (20)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .play_pause (play_pause),
      .reverse    (reverse),
      .tempo_up   (tempo_up),
      .tempo_down (tempo_down),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .tone       (tone),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= 24'(rom_addr) + 24'd1;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      since_step++;
   endtask

   task automatic pulse(input logic pp, input logic rv, input logic up, input logic dn);
      play_pause = pp;
      reverse    = rv;
      tempo_up   = up;
      tempo_down = dn;
      tick();
      play_pause = 1'b0;
      reverse    = 1'b0;
      tempo_up   = 1'b0;
      tempo_down = 1'b0;
   endtask

   // exp_len < 0 skips the note-length check (note started before a pause).
   task automatic wait_step(input int exp_addr, input int exp_len, input bit tone_chk);
      logic [2:0] prev;
      int n;
      prev = rom_addr;
      n = 0;
      while (rom_addr == prev && n < 100) begin
         tick();
         n++;
      end
      chk("step_timeout", (n < 100) ? 1 : 0, 1);
      chk("step_addr", rom_addr, exp_addr);
      if (exp_len > 0) chk("note_len", since_step, exp_len);
      since_step = 0;
      if (tone_chk) begin
         tick();
         tick();
         chk("tone_lag", tone, exp_addr + 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      total = 0;
      bad = 0;
      since_step = 0;
      rst_n = 1'b0;
      play_pause = 1'b0;
      reverse = 1'b0;
      tempo_up = 1'b0;
      tempo_down = 1'b0;
      tick();
      tick();
      chk("rst_state", state, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_tone", tone, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 100; i++) begin
         tick();
         chk("idle_state", state, 0);
         chk("idle_addr", rom_addr, 0);
         chk("idle_tone", tone, 0);
      end

      // forward play with full wrap, then on to address 2
      pulse(1, 0, 0, 0);
      since_step = 0;
      chk("play_state", state, 1);
      chk("play_tone0", tone, 1);
      for (int a = 1; a <= 10; a++) wait_step(a % 8, 10, 1);

      // reverse mid-note keeps the counter, steps down through the wrap
      pulse(0, 1, 0, 0);
      chk("rev_state", state, 2);
      wait_step(1, 10, 1);
      wait_step(0, 10, 1);
      wait_step(7, 10, 1);
      wait_step(6, 10, 1);

      pulse(1, 0, 0, 0);
      chk("pause_state", state, 0);
      chk("pause_tone", tone, 0);
      for (int i = 0; i < 30; i++) tick();
      chk("pause_addr_hold", rom_addr, 6);
      chk("pause_tone_hold", tone, 0);
      pulse(1, 0, 0, 0);
      since_step = 3;
      chk("resume_state", state, 2);
      chk("resume_tone", tone, 7);
      wait_step(5, 10, 1);

      // tempo saturation at minimum
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      wait_step(4, -1, 0);
      wait_step(3, 2, 0);
      wait_step(2, 2, 0);

      // tempo saturation at maximum, then simultaneous up/down
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 12; i++) pulse(0, 0, 0, 1);
      pulse(1, 0, 0, 0);
      wait_step(1, -1, 0);
      wait_step(0, 20, 1);
      pulse(0, 0, 1, 1);
      wait_step(7, 20, 1);

      // back to tempo 10, then shorten mid-note past the counter
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      wait_step(6, -1, 0);
      wait_step(5, 10, 1);
      for (int i = 0; i < 4; i++) tick();
      tempo_up = 1'b1;
      tick();
      chk("early_up_hold", rom_addr, 5);
      tick();
      tempo_up = 1'b0;
      chk("early_end_addr", rom_addr, 4);
      since_step = 0;
      wait_step(3, 6, 1);

      // tempo 4, reset mid-note at address 5
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      wait_step(2, -1, 0);
      wait_step(1, 4, 0);
      wait_step(0, 4, 0);
      wait_step(7, 4, 0);
      wait_step(6, 4, 0);
      wait_step(5, 4, 0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", state, 0);
      chk("async_rst_addr", rom_addr, 0);
      chk("async_rst_tone", tone, 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("post_rst_tone", tone, 0);
      chk("post_rst_state", state, 0);
      pulse(1, 0, 0, 0);
      since_step = 0;
      chk("post_rst_play", state, 1);
      wait_step(1, 10, 1);

      // direction handling in pause and combined pulses
      pulse(0, 1, 0, 0);
      chk("rev_in_play", state, 2);
      pulse(1, 0, 0, 0);
      chk("pause_again", state, 0);
      pulse(0, 1, 0, 0);
      chk("rev_in_pause", state, 0);
      pulse(1, 0, 0, 0);
      chk("resume_fwd", state, 1);
      pulse(1, 1, 0, 0);
      chk("combo_pause", state, 0);
      pulse(1, 0, 0, 0);
      chk("combo_resume_rev", state, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
